// File: rtl/ntt_arb_pkg.sv
// rtl/ntt_arb_pkg.sv - shared types and defaults for the NTT job arbiter
package ntt_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    START,
    RUN,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    NTT  = 1'b0,
    INTT = 1'b1
  } ntt_mode_t;

  localparam int DEF_WDOG_CYCLES = 4096;

endpackage

// File: rtl/ntt_job_arbiter_if.sv
// rtl/ntt_job_arbiter_if.sv - requester and engine signals of the NTT job arbiter
interface ntt_job_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_mode;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] done_out;
  logic               timeout_out;
  logic               eng_enable;
  logic               eng_mode;
  logic [SEL_W-1:0]   eng_sel;
  logic               eng_abort;
  logic               eng_done;

  modport master (
    input  req, req_mode, eng_done,
    output gnt, done_out, timeout_out, eng_enable, eng_mode, eng_sel, eng_abort
  );

  modport slave (
    output req, req_mode, eng_done,
    input  gnt, done_out, timeout_out, eng_enable, eng_mode, eng_sel, eng_abort
  );

endinterface

// File: rtl/ntt_job_arbiter_rr_picker.sv
// rtl/ntt_job_arbiter_rr_picker.sv - combinational round-robin winner search
module rr_picker
  import ntt_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   rr_ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               any_req
);

  int               idx;
  logic [SEL_W-1:0] idx_b;

  // Walk offsets from farthest to nearest so the nearest set bit at or
  // after rr_ptr is the one left standing.
  always_comb begin
    winner  = '0;
    any_req = |req;
    idx     = 0;
    idx_b   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx   = (int'(rr_ptr) + k) % NUM_REQ;
      idx_b = SEL_W'(idx);
      if (req[idx_b]) begin
        winner = idx_b;
      end
    end
  end

endmodule

// File: rtl/ntt_job_arbiter.sv
// rtl/ntt_job_arbiter.sv - round-robin owner of one NTT engine; watchdog under NTT_ARB_WATCHDOG_EN
module ntt_job_arbiter
  import ntt_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int SEL_W       = $clog2(NUM_REQ),
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  ntt_job_arbiter_if.master bus,
  output logic              busy,
  output logic              proto_err
);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] sel_nxt;
  logic             mode_nxt;
  logic             any_req;
  logic             expire;
  logic             owns_nxt;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_picker (
    .req     (bus.req),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

`ifdef NTT_ARB_WATCHDOG_EN
  localparam int WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;

  logic [WDOG_W-1:0] wdog_cnt;

  // A done arriving on the expiry cycle takes precedence over the abort.
  assign expire = (state == RUN) && !bus.eng_done &&
                  (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt        <= '0;
      bus.eng_abort   <= 1'b0;
      bus.timeout_out <= 1'b0;
    end else begin
      if (state == START) begin
        wdog_cnt <= '0;
      end else if (state == RUN) begin
        wdog_cnt <= wdog_cnt + WDOG_W'(1);
      end
      bus.eng_abort   <= expire;
      bus.timeout_out <= expire;
    end
  end
`else
  assign expire          = 1'b0;
  assign bus.eng_abort   = 1'b0;
  assign bus.timeout_out = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    sel_nxt   = bus.eng_sel;
    mode_nxt  = bus.eng_mode;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt = ARB;
        end
      end
      ARB: begin
        if (any_req) begin
          state_nxt = START;
          sel_nxt   = winner;
          mode_nxt  = bus.req_mode[winner];
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (bus.eng_done || expire) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign owns_nxt = (state_nxt == START) || (state_nxt == RUN) || (state_nxt == RELEASE);

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      bus.gnt        <= '0;
      bus.done_out   <= '0;
      bus.eng_enable <= 1'b0;
      bus.eng_mode   <= 1'b0;
      bus.eng_sel    <= '0;
      busy           <= 1'b0;
      proto_err      <= 1'b0;
    end else begin
      state          <= state_nxt;
      bus.eng_sel    <= sel_nxt;
      bus.eng_mode   <= mode_nxt;
      bus.eng_enable <= (state_nxt == START);
      bus.gnt        <= owns_nxt ? onehot(sel_nxt) : '0;
      bus.done_out   <= (state_nxt == RELEASE) ? onehot(sel_nxt) : '0;
      busy           <= (state_nxt != IDLE);
      if (bus.eng_done && (state != RUN)) begin
        proto_err <= 1'b1;
      end
      if ((state == RUN) && (state_nxt == RELEASE)) begin
        rr_ptr <= (bus.eng_sel == SEL_W'(NUM_REQ - 1)) ? '0 : bus.eng_sel + SEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ntt_job_arbiter.sv
// tb/tb_ntt_job_arbiter.sv - randomized reference-model bench for ntt_job_arbiter
module tb_ntt_job_arbiter;

  localparam int N  = 4;
  localparam int SW = 2;
`ifdef NTT_ARB_WATCHDOG_EN
  localparam int WD    = 16;
  localparam bit WD_ON = 1'b1;
`else
  localparam int WD    = 4096;
  localparam bit WD_ON = 1'b0;
`endif

  localparam int S_FREE  = 0;
  localparam int S_PICK  = 1;
  localparam int S_START = 2;
  localparam int S_RUN   = 3;
  localparam int S_FIN   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic proto_err;

  always #5 clk = ~clk;

  ntt_job_arbiter_if #(.NUM_REQ(N), .SEL_W(SW)) bus ();

  ntt_job_arbiter #(
    .NUM_REQ     (N),
    .SEL_W       (SW),
    .WDOG_CYCLES (WD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .proto_err (proto_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: job timeline in plain integers
  int m_stage = S_FREE;
  int m_owner = 0;
  int m_rr    = 0;
  int m_mode  = 0;
  int m_wcnt  = 0;
  bit m_perr  = 1'b0;
  bit m_tmo   = 1'b0;

  // stimulus control
  bit         rand_en   = 1'b0;
  bit         hold_en   = 1'b0;
  bit         rec_en    = 1'b0;
  bit         spur_done = 1'b0;
  int         fixed_lat = 0;
  int         eng_cd    = 0;
  logic [N-1:0] drop_mask = '0;
  logic [N-1:0] fin_mask  = '0;
  int         order_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // nearest requester at or after the pointer, by circular distance
  function automatic int pick(input logic [N-1:0] r, input int rr);
    int best = -1;
    int bd   = N;
    for (int i = 0; i < N; i++) begin
      if (r[i] && (((i - rr + N) % N) < bd)) begin
        bd   = (i - rr + N) % N;
        best = i;
      end
    end
    return best;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_stage = S_FREE; m_owner = 0; m_rr = 0; m_mode = 0;
      m_wcnt = 0; m_perr = 1'b0; m_tmo = 1'b0;
      return;
    end
    if (bus.eng_done && m_stage != S_RUN) m_perr = 1'b1;
    m_tmo = 1'b0;
    case (m_stage)
      S_FREE: if (bus.req != 0) m_stage = S_PICK;
      S_PICK: begin
        if (bus.req == 0) m_stage = S_FREE;
        else begin
          m_owner = pick(bus.req, m_rr);
          m_mode  = int'(bus.req_mode[m_owner]);
          m_stage = S_START;
        end
      end
      S_START: begin m_wcnt = 0; m_stage = S_RUN; end
      S_RUN: begin
        if (bus.eng_done) m_stage = S_FIN;
        else if (WD_ON && m_wcnt == WD - 1) begin m_stage = S_FIN; m_tmo = 1'b1; end
        else m_wcnt++;
      end
      default: begin m_rr = (m_owner + 1) % N; m_stage = S_FREE; end
    endcase
  endtask

  task automatic check_outputs();
    logic [N-1:0] own = N'(1) << m_owner;
    check_eq("gnt", bus.gnt, (m_stage >= S_START) ? own : '0);
    check_eq("gnt_onehot", ($countones(bus.gnt) <= 1), 1);
    check_eq("eng_enable", bus.eng_enable, (m_stage == S_START));
    check_eq("done_out", bus.done_out, (m_stage == S_FIN) ? own : '0);
    check_eq("busy", busy, (m_stage != S_FREE));
    check_eq("proto_err", proto_err, m_perr);
    check_eq("timeout_out", bus.timeout_out, (m_stage == S_FIN) && m_tmo);
    check_eq("eng_abort", bus.eng_abort, (m_stage == S_FIN) && m_tmo);
    check_eq("eng_sel", bus.eng_sel, m_owner);
    check_eq("eng_mode", bus.eng_mode, m_mode);
  endtask

  // set this cycle's inputs, advance the model, then compare at the negedge
  task automatic cycle();
    if (!hold_en) bus.req = bus.req & ~drop_mask;
    if (rand_en) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && !drop_mask[i] && $urandom_range(0, 3) == 0) begin
          bus.req[i]      = 1'b1;
          bus.req_mode[i] = 1'($urandom_range(0, 1));
        end else if ($urandom_range(0, 7) == 0) begin
          bus.req_mode[i] = ~bus.req_mode[i];
        end
      end
    end
    if (spur_done) begin
      bus.eng_done = 1'b1;
      spur_done    = 1'b0;
    end else if (m_stage == S_START) begin
      eng_cd       = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 20));
      bus.eng_done = 1'b0;
    end else if (m_stage == S_RUN && eng_cd > 0) begin
      eng_cd--;
      bus.eng_done = (eng_cd == 0);
    end else begin
      bus.eng_done = 1'b0;
    end
    if (!rst_n) eng_cd = 0;
    model_step();
    @(negedge clk);
    check_outputs();
    if (rec_en && bus.eng_enable) order_q.push_back(int'(bus.eng_sel));
    drop_mask = fin_mask;
    fin_mask  = (m_stage == S_FIN) ? (N'(1) << m_owner) : '0;
  endtask

  initial begin
    int exp_ord[6] = '{0, 1, 3, 0, 1, 3};
    bit seen;
    bit en_seen;

    bus.req = '0; bus.req_mode = '0; bus.eng_done = 1'b0;
    rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;

    // single INTT job for requester 1, engine answers 20 cycles after enable
    bus.req_mode = 4'b0010; bus.req = 4'b0010; fixed_lat = 20;
    cycle();
    cycle();
    check_eq("t1_enable", bus.eng_enable, 1);
    check_eq("t1_mode", bus.eng_mode, 1);
    check_eq("t1_sel", bus.eng_sel, 1);
    check_eq("t1_gnt", bus.gnt, 4'b0010);
    repeat (21) cycle();
    check_eq("t1_done", bus.done_out, 4'b0010);
    repeat (4) cycle();

    // continuous requests from reset rotate 0,1,3
    rst_n = 1'b0; bus.req = 4'b1011; bus.req_mode = 4'b1001;
    hold_en = 1'b1; rec_en = 1'b1; fixed_lat = 3; order_q.delete();
    cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 200 && order_q.size() < 6; c++) cycle();
    check_eq("t2_count", (order_q.size() >= 6), 1);
    for (int i = 0; i < 6 && i < order_q.size(); i++) check_eq("t2_order", order_q[i], exp_ord[i]);
    bus.req = '0; hold_en = 1'b0; rec_en = 1'b0;
    repeat (12) cycle();

    // engine done while idle
    spur_done = 1'b1;
    cycle();
    check_eq("t3_no_done", bus.done_out, 0);
    repeat (3) cycle();
    check_eq("t3_perr", proto_err, 1);
    check_eq("t3_busy", busy, 0);

    // reset in the middle of a running job
    bus.req = 4'b0001; fixed_lat = 5;
    repeat (15) cycle();
    bus.req = 4'b0010; fixed_lat = 50;
    for (int c = 0; c < 10 && m_stage != S_RUN; c++) cycle();
    repeat (3) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; bus.req = '0;
    check_eq("t4_gnt", bus.gnt, 0);
    check_eq("t4_perr", proto_err, 0);
    bus.req = 4'b0101; fixed_lat = 3;
    cycle();
    cycle();
    check_eq("t4_first_sel", bus.eng_sel, 0);
    check_eq("t4_first_en", bus.eng_enable, 1);
    repeat (25) cycle();

    // one-cycle request pulse is withdrawn before arbitration
    bus.req = 4'b0001;
    cycle();
    bus.req = '0; en_seen = 1'b0;
    repeat (5) begin
      cycle();
      en_seen |= bus.eng_enable;
    end
    check_eq("t5_no_enable", en_seen, 0);

`ifdef NTT_ARB_WATCHDOG_EN
    // engine never answers: watchdog aborts, next requester served normally
    bus.req = 4'b0010; fixed_lat = 1000; seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      cycle();
      if (bus.done_out != 0) begin
        seen = 1'b1;
        check_eq("t6_tmo", bus.timeout_out, 1);
        check_eq("t6_abort", bus.eng_abort, 1);
      end
    end
    check_eq("t6_wait_abort", seen, 1);
    repeat (2) cycle();
    bus.req = 4'b0100; fixed_lat = 4; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      cycle();
      if (bus.done_out != 0) begin
        seen = 1'b1;
        check_eq("t6_next_done", bus.done_out, 4'b0100);
        check_eq("t6_next_tmo", bus.timeout_out, 0);
      end
    end
    check_eq("t6_wait_next", seen, 1);
    repeat (4) cycle();
`endif

    // randomized traffic against the model
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; bus.req = '0; rand_en = 1'b1; fixed_lat = 0;
    repeat (3000) cycle();
    rand_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
